traffic_phase_sequencer: RTL and testbench
==========================================

# traffic_phase_sequencer

Phase sequencer for the four-approach traffic light controller. It owns the current-phase code `cs` that selects the green delay in the timer, restarts and enables the timer, and consumes the timer's expiry. It also drives the per-approach green/yellow lamps through yellow and all-red clearance intervals, and picks the next phase by round-robin over approaches with pending vehicle demand. An emergency request can pre-empt the rotation.

## Interface

Parameters:
- `YEL_CYC`, default 3: yellow interval length in clocks, legal range 1..15.
- `AR_CYC`, default 1: all-red interval length in clocks, legal range 1..15.

Ports:
- `clk`, input, 1 bit: system clock; all state changes on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset.
- `enable`, input, 1 bit: run request; low parks the block in IDLE.
- `car_waiting`, input, 4 bits: per-approach vehicle sensors, bit n is approach n.
- `emerg_req`, input, 1 bit: emergency pre-emption request, level sensitive.
- `emerg_dir`, input, 2 bits: approach to give to the emergency vehicle; valid while `emerg_req` is high.
- `tmr_done`, input, 1 bit: one-clock pulse from the timer when the programmed delay for `cs` has elapsed.
- `cs`, output, 2 bits: current phase and timer delay select.
- `tmr_clr_n`, output, 1 bit: active-low, one-clock timer restart.
- `tmr_en`, output, 1 bit: timer count enable.
- `green`, output, 4 bits: one-hot green lamps.
- `yellow`, output, 4 bits: one-hot yellow lamps. Red is implied wherever neither `green` nor `yellow` is set.

## Operation

- States: IDLE, START, GREEN, YELLOW, ALLRED, EMERG. The encoding is free.
- `pending[3:0]` holds sticky demand.
  - Set: `pending |= car_waiting` every clock.
  - Clear: bit `cs` is cleared on the clock the block is in START. A set request for the same bit in that clock is dropped, because that approach is being served.
- Next-phase pick, `nxt`: the first of `cs+1`, `cs+2`, `cs+3` (mod 4) whose pending bit is set. If none is set, `nxt = cs`.
- IDLE: all lamps red, `tmr_en=0`, `tmr_clr_n=1`. If `enable`=1, go to START. `cs` keeps its value.
- START (one clock): `green[cs]=1`, `tmr_clr_n=0`, `tmr_en=0`. Always go to GREEN.
- GREEN: `green[cs]=1`, `tmr_en=1`. Exits, in priority order:
  - `emerg_req` and `emerg_dir==cs`: go to EMERG.
  - `emerg_req` and `emerg_dir!=cs`: latch `tgt=emerg_dir`, go to YELLOW.
  - `tmr_done` and `nxt==cs`: go to START (green extension, no yellow).
  - `tmr_done` and `nxt!=cs`: latch `tgt=nxt`, go to YELLOW.
- YELLOW: `yellow[cs]=1`, `tmr_en=0`. Stay `YEL_CYC` clocks, then go to ALLRED.
- ALLRED: all red, `tmr_en=0`. Stay `AR_CYC` clocks. On exit:
  - Load `cs <= emerg_req ? emerg_dir : tgt`.
  - Go to START.
- EMERG: `green[cs]=1`, `tmr_en=0`. Stay while `emerg_req` is high. When it drops, go to START.
- `enable`=0 in any state except IDLE: go to IDLE on the next edge, lamps go all red. This is an abrupt stop, accepted for maintenance mode only.
- Interval counter: 4-bit, loaded with the interval length on entry to YELLOW or ALLRED, decremented each clock, exit when it reaches 1.
- Invariant: at most one bit set across `green|yellow` at any time.

## Timing

- Reset values: state IDLE, `cs=0`, `pending=0`, `tgt=0`, `green=0`, `yellow=0`, `tmr_en=0`, `tmr_clr_n=1`.
- All outputs are registered, or decoded from registered state only; no input-to-output combinational paths.
- From `enable` rising at edge k:
  - START is visible after edge k+1.
  - GREEN is visible after edge k+2.
- `tmr_done` in GREEN at edge k:
  - With `nxt!=cs`: `yellow[cs]` is set from edge k+1 for `YEL_CYC` clocks, then all red for `AR_CYC` clocks, then START on the new `cs`.
  - Total gap between greens = `YEL_CYC + AR_CYC` clocks.
- `tmr_done` outside GREEN is ignored.
- `tmr_done` and `emerg_req` on the same clock: the emergency exit wins.
- `car_waiting` arriving during YELLOW or ALLRED is captured in `pending` and considered at the next GREEN expiry.
- Asynchronous reset mid-interval: all lamps clear immediately and return to IDLE. No yellow is shown.

## Test plan

- Reset, then `enable=1`, `car_waiting=0`:
  - `tmr_clr_n` pulses low for one clock and green[0] stays on.
  - Every `tmr_done` produces START again; `cs` stays 0 and `yellow` is never set.
- `car_waiting=4'b1010` pulsed, `cs=0`, defaults `YEL_CYC=3`, `AR_CYC=1`:
  - `tmr_done` gives 3 clocks of yellow[0], then 1 clock all red, then green[1].
  - The next expiry moves to green[3], and pending ends at 0.
- `car_waiting=4'b0100` asserted in the same clock as `tmr_done` with `cs=1`:
  - `cs` stays 1 (demand not yet latched).
  - The next expiry goes to `cs=2`.
- `emerg_req=1`, `emerg_dir=2` while `cs=0` is green mid-interval:
  - Immediate yellow[0], then all red, then green[2], then EMERG with `tmr_en=0`.
  - Drop `emerg_req`: START, `tmr_clr_n` pulse, normal rotation resumes.
- Emergency arriving during ALLRED with `emerg_dir=3`, `tgt=1`:
  - `cs` loads 3, not 1.
- `reset` low mid-YELLOW: all outputs clear asynchronously. `enable=0` during GREEN: IDLE, all red on the next edge, and re-enable restarts the same `cs`.
- Every test: assert `popcount(green|yellow)<=1` on every clock.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// Four-approach phase sequencer: green/yellow/all-red rotation over
// pending demand, timer control and emergency pre-emption.
module traffic_phase_sequencer #(
  parameter int unsigned YEL_CYC = 3,
  parameter int unsigned AR_CYC  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] car_waiting,
  input  logic       emerg_req,
  input  logic [1:0] emerg_dir,
  input  logic       tmr_done,
  output logic [1:0] cs,
  output logic       tmr_clr_n,
  output logic       tmr_en,
  output logic [3:0] green,
  output logic [3:0] yellow
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] GREEN  = 3'd2;
  localparam logic [2:0] YELLOW = 3'd3;
  localparam logic [2:0] ALLRED = 3'd4;
  localparam logic [2:0] EMERG  = 3'd5;

  localparam logic [3:0] YEL_LD = 4'(YEL_CYC);
  localparam logic [3:0] AR_LD  = 4'(AR_CYC);

  logic [2:0] state_q, state_d;
  logic [1:0] cs_q, cs_d;
  logic [1:0] tgt_q, tgt_d;
  logic [3:0] pend_q, pend_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] nxt;
  logic [1:0] c1, c2, c3;
  logic [3:0] cs_oh;

  assign c1 = cs_q + 2'd1;
  assign c2 = cs_q + 2'd2;
  assign c3 = cs_q + 2'd3;

  // Round-robin: nearest approach after the current one wins.
  always_comb begin
    nxt = cs_q;
    priority case (1'b1)
      pend_q[c1]: nxt = c1;
      pend_q[c2]: nxt = c2;
      pend_q[c3]: nxt = c3;
      default:    nxt = cs_q;
    endcase
  end

  // The served approach drops its demand, even if re-requested now.
  always_comb begin
    pend_d = pend_q | car_waiting;
    if (state_q == START) pend_d[cs_q] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  state_d = START;
        START: state_d = GREEN;
        GREEN: begin
          if (emerg_req && emerg_dir == cs_q) begin
            state_d = EMERG;
          end else if (emerg_req) begin
            tgt_d   = emerg_dir;
            state_d = YELLOW;
            cnt_d   = YEL_LD;
          end else if (tmr_done) begin
            if (nxt == cs_q) begin
              state_d = START;
            end else begin
              tgt_d   = nxt;
              state_d = YELLOW;
              cnt_d   = YEL_LD;
            end
          end
        end
        YELLOW: begin
          if (cnt_q <= 4'd1) begin
            state_d = ALLRED;
            cnt_d   = AR_LD;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ALLRED: begin
          if (cnt_q <= 4'd1) begin
            cs_d    = emerg_req ? emerg_dir : tgt_q;
            state_d = START;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        EMERG: begin
          if (!emerg_req) state_d = START;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cs_q    <= 2'd0;
      tgt_q   <= 2'd0;
      pend_q  <= 4'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cs_oh = 4'b0001 << cs_q;
  assign cs    = cs_q;

  // Lamps and timer strobes decode registered state only.
  assign green = (state_q == START || state_q == GREEN ||
                  state_q == EMERG) ? cs_oh : 4'd0;
  assign yellow    = (state_q == YELLOW) ? cs_oh : 4'd0;
  assign tmr_clr_n = (state_q != START);
  assign tmr_en    = (state_q == GREEN);

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Vector/scoreboard bench for traffic_phase_sequencer with
// default yellow and all-red intervals.
module tb_traffic_phase_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] car_waiting;
  logic       emerg_req;
  logic [1:0] emerg_dir;
  logic       tmr_done;
  logic [1:0] cs;
  logic       tmr_clr_n;
  logic       tmr_en;
  logic [3:0] green;
  logic [3:0] yellow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [3:0]  cw;
    logic        er;
    logic [1:0]  ed;
    logic        td;
    logic [11:0] exp;
  } vec_t;

  vec_t        vt[$];
  logic [11:0] sb[$];

  traffic_phase_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .car_waiting (car_waiting),
    .emerg_req   (emerg_req),
    .emerg_dir   (emerg_dir),
    .tmr_done    (tmr_done),
    .cs          (cs),
    .tmr_clr_n   (tmr_clr_n),
    .tmr_en      (tmr_en),
    .green       (green),
    .yellow      (yellow)
  );

  always #5 clk = ~clk;

  // Packed {cs, green, yellow, tmr_en, tmr_clr_n}
  function automatic logic [3:0] oh(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction
  function automatic logic [11:0] e_idle(input logic [1:0] c);
    return {c, 4'd0, 4'd0, 1'b0, 1'b1};
  endfunction
  function automatic logic [11:0] e_st(input logic [1:0] c);
    return {c, oh(c), 4'd0, 1'b0, 1'b0};
  endfunction
  function automatic logic [11:0] e_gr(input logic [1:0] c);
    return {c, oh(c), 4'd0, 1'b1, 1'b1};
  endfunction
  function automatic logic [11:0] e_ye(input logic [1:0] c);
    return {c, 4'd0, oh(c), 1'b0, 1'b1};
  endfunction
  function automatic logic [11:0] e_ar(input logic [1:0] c);
    return {c, 4'd0, 4'd0, 1'b0, 1'b1};
  endfunction
  function automatic logic [11:0] e_em(input logic [1:0] c);
    return {c, oh(c), 4'd0, 1'b0, 1'b1};
  endfunction

  function automatic logic [11:0] outs();
    return {cs, green, yellow, tmr_en, tmr_clr_n};
  endfunction

  task automatic check(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cs,g,y,en,clrn)", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [3:0] cw,
                     input logic er, input logic [1:0] ed,
                     input logic td, input logic [11:0] exp);
    vec_t v;
    v.en = en; v.cw = cw; v.er = er; v.ed = ed; v.td = td; v.exp = exp;
    vt.push_back(v);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if ($countones(green | yellow) > 1) begin
        errors++;
        $display("FAIL lamp_onehot: g=%b y=%b", green, yellow);
      end
    end
  end

  initial begin
    // Idle extension, no demand
    add(1, 4'h0, 0, 0, 0, e_st(0));
    add(1, 4'h0, 0, 0, 0, e_gr(0));
    add(1, 4'h0, 0, 0, 1, e_st(0));
    add(1, 4'h0, 0, 0, 0, e_gr(0));
    add(1, 4'h0, 0, 0, 0, e_gr(0));
    add(1, 4'h0, 0, 0, 1, e_st(0));
    add(1, 4'h0, 0, 0, 0, e_gr(0));
    // Demand 1010: 0 -> 1 -> 3
    add(1, 4'hA, 0, 0, 0, e_gr(0));
    add(1, 4'h0, 0, 0, 0, e_gr(0));
    add(1, 4'h0, 0, 0, 1, e_ye(0));
    add(1, 4'h0, 0, 0, 0, e_ye(0));
    add(1, 4'h0, 0, 0, 0, e_ye(0));
    add(1, 4'h0, 0, 0, 0, e_ar(0));
    add(1, 4'h0, 0, 0, 0, e_st(1));
    add(1, 4'h0, 0, 0, 0, e_gr(1));
    add(1, 4'h0, 0, 0, 1, e_ye(1));
    add(1, 4'h0, 0, 0, 0, e_ye(1));
    add(1, 4'h0, 0, 0, 0, e_ye(1));
    add(1, 4'h0, 0, 0, 0, e_ar(1));
    add(1, 4'h0, 0, 0, 0, e_st(3));
    add(1, 4'h0, 0, 0, 0, e_gr(3));
    add(1, 4'h0, 0, 0, 1, e_st(3));
    add(1, 4'h0, 0, 0, 0, e_gr(3));
    // Demand with expiry same clock; demand during yellow
    add(1, 4'h4, 0, 0, 1, e_st(3));
    add(1, 4'h0, 0, 0, 0, e_gr(3));
    add(1, 4'h0, 0, 0, 1, e_ye(3));
    add(1, 4'h1, 0, 0, 0, e_ye(3));
    add(1, 4'h0, 0, 0, 0, e_ye(3));
    add(1, 4'h0, 0, 0, 0, e_ar(3));
    add(1, 4'h0, 0, 0, 0, e_st(2));
    add(1, 4'h0, 0, 0, 0, e_gr(2));
    add(1, 4'h0, 0, 0, 1, e_ye(2));
    add(1, 4'h0, 0, 0, 0, e_ye(2));
    add(1, 4'h0, 0, 0, 0, e_ye(2));
    add(1, 4'h0, 0, 0, 0, e_ar(2));
    add(1, 4'h0, 0, 0, 0, e_st(0));
    add(1, 4'h0, 0, 0, 0, e_gr(0));
    // Emergency to 2 (with same-clock expiry), td ignored elsewhere
    add(1, 4'h0, 1, 2, 1, e_ye(0));
    add(1, 4'h0, 1, 2, 1, e_ye(0));
    add(1, 4'h0, 1, 2, 0, e_ye(0));
    add(1, 4'h0, 1, 2, 0, e_ar(0));
    add(1, 4'h0, 1, 2, 0, e_st(2));
    add(1, 4'h0, 1, 2, 0, e_gr(2));
    add(1, 4'h0, 1, 2, 0, e_em(2));
    add(1, 4'h0, 1, 2, 1, e_em(2));
    add(1, 4'h0, 0, 0, 0, e_st(2));
    add(1, 4'h0, 0, 0, 0, e_gr(2));
    // tgt=1, emergency to 3 arrives in all-red
    add(1, 4'h2, 0, 0, 0, e_gr(2));
    add(1, 4'h0, 0, 0, 1, e_ye(2));
    add(1, 4'h0, 0, 0, 0, e_ye(2));
    add(1, 4'h0, 0, 0, 0, e_ye(2));
    add(1, 4'h0, 0, 0, 0, e_ar(2));
    add(1, 4'h0, 1, 3, 0, e_st(3));
    add(1, 4'h0, 1, 3, 0, e_gr(3));
    add(1, 4'h0, 1, 3, 0, e_em(3));
    add(1, 4'h0, 0, 0, 0, e_st(3));
    add(1, 4'h0, 0, 0, 0, e_gr(3));
    // Maintenance stop and restart on same cs
    add(0, 4'h0, 0, 0, 0, e_idle(3));
    add(0, 4'h0, 0, 0, 1, e_idle(3));
    add(1, 4'h0, 0, 0, 0, e_st(3));
    add(1, 4'h0, 0, 0, 0, e_gr(3));
    add(1, 4'h0, 0, 0, 1, e_ye(3));
    add(1, 4'h0, 0, 0, 0, e_ye(3));

    reset       = 1'b0;
    enable      = 1'b0;
    car_waiting = 4'd0;
    emerg_req   = 1'b0;
    emerg_dir   = 2'd0;
    tmr_done    = 1'b0;
    #12;
    check("reset_state", outs(), e_idle(0));
    reset = 1'b1;

    foreach (vt[i]) begin
      enable      = vt[i].en;
      car_waiting = vt[i].cw;
      emerg_req   = vt[i].er;
      emerg_dir   = vt[i].ed;
      tmr_done    = vt[i].td;
      sb.push_back(vt[i].exp);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: vec %0d", i);
      end else begin
        check($sformatf("vec%0d", i), outs(), sb.pop_front());
      end
    end

    // Asynchronous reset in the middle of yellow
    enable = 1'b1;
    car_waiting = 4'd0;
    tmr_done = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_now", outs(), e_idle(0));
    @(posedge clk);
    #1;
    check("async_rst_held", outs(), e_idle(0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_start", outs(), e_st(0));
    @(posedge clk);
    #1;
    check("post_rst_green", outs(), e_gr(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
